// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encoding and S-box function
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_fsm_t;

    // Indexed directly by the 4-bit round counter; unused slots are zero.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - combinational single-step AES-128 key expansion
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] sub_rot;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ sub_rot ^ {rcon, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 round controller; AES_SEQ_DBG_EN adds dbg_round/dbg_fsm
module aes_round_sequencer
    import aes_pkg::aes_fsm_t;
    import aes_pkg::IDLE;
    import aes_pkg::ROUND;
    import aes_pkg::DONE;
    import aes_pkg::RCON;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [127:0] rnd_state_o,
    output logic [127:0] rnd_key_o,
    output logic         rnd_last_o,
    input  logic [127:0] rnd_result_i,
    output logic         busy
`ifdef AES_SEQ_DBG_EN
    ,
    output logic [3:0]   dbg_round,
    output logic [1:0]   dbg_fsm
`endif
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    aes_fsm_t     fsm_q;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic         in_round;
    logic [127:0] next_key;

    assign in_round = (fsm_q == ROUND);

    aes_key_step u_key_step (
        .key_in  (key_q),
        .rcon    (RCON[round_q]),
        .key_out (next_key)
    );

    // Decoded from the async-reset FSM register so they clear without a clock.
    assign rnd_state_o = in_round ? state_q  : 128'h0;
    assign rnd_key_o   = in_round ? next_key : 128'h0;
    assign rnd_last_o  = in_round && (round_q == LAST_ROUND);

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign ciphertext = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= 128'h0;
            key_q       <= 128'h0;
            round_q     <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= plaintext ^ key;
                        key_q      <= key;
                        round_q    <= 4'd1;
                        fsm_q      <= ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ROUND: begin
                    state_q <= rnd_result_i;
                    key_q   <= next_key;
                    round_q <= round_q + 4'd1;
                    if (round_q == LAST_ROUND) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_SEQ_DBG_EN
    assign dbg_round = round_q;
    assign dbg_fsm   = fsm_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer with a behavioural round core
`timescale 1ns/1ps
module tb_aes_round_sequencer;
    import aes_pkg::sbox;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic [127:0] rnd_state_o;
    logic [127:0] rnd_key_o;
    logic         rnd_last_o;
    logic [127:0] rnd_result_i;
    logic         busy;
`ifdef AES_SEQ_DBG_EN
    logic [3:0]   dbg_round;
    logic [1:0]   dbg_fsm;
`endif

    aes_round_sequencer #(.NR(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .plaintext    (plaintext),
        .key          (key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ciphertext   (ciphertext),
        .rnd_state_o  (rnd_state_o),
        .rnd_key_o    (rnd_key_o),
        .rnd_last_o   (rnd_last_o),
        .rnd_result_i (rnd_result_i),
        .busy         (busy)
`ifdef AES_SEQ_DBG_EN
        ,
        .dbg_round    (dbg_round),
        .dbg_fsm      (dbg_fsm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Behavioural AES_main-style round: SubBytes, ShiftRows, MixColumns (skipped on last), AddRoundKey.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[rw + 4*c] = b[rw + 4*((c + rw) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    always_comb rnd_result_i = aes_round(rnd_state_o, rnd_key_o, rnd_last_o);

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];
    logic [127:0] exp_q [$];
    int tests;
    int fails;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on every output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %h expected no output", ciphertext);
            end else begin
                check("ciphertext", ciphertext, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] ct);
        plaintext = p;
        key       = k;
        in_valid  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ct);
                step();
                in_valid = 1'b0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            if (exp_q.size() == 0) return;
            step();
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        vecs[0] = '{pt: B_PT, key: B_KEY, ct: B_CT};
        vecs[1] = '{pt: C_PT, key: C_KEY, ct: C_CT};
        vecs[2] = '{pt: 128'h0, key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        tests = 0;
        fails = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key = '0;

        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ciphertext", ciphertext, 0);
        check("rst_rnd_state", rnd_state_o, 0);
        check("rst_rnd_key", rnd_key_o, 0);
        check("rst_rnd_last", rnd_last_o, 0);
`ifdef AES_SEQ_DBG_EN
        check("rst_dbg_round", dbg_round, 0);
        check("rst_dbg_fsm", dbg_fsm, 0);
`endif
        rst = 1'b0;
        step();

        // App. B first-round presentation to the round core
        out_ready = 1'b1;
        send(B_PT, B_KEY, B_CT);
        check("b_rnd_state", rnd_state_o, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        check("b_rnd_key", rnd_key_o, 128'ha0fafe1788542cb123a339392a6c7605);
        check("b_rnd_last", rnd_last_o, 0);
        check("b_busy", busy, 1);
        check("b_in_ready", in_ready, 0);
        drain();

        for (int i = 0; i < 3; i++) begin
            send(vecs[i].pt, vecs[i].key, vecs[i].ct);
            drain();
        end

        // App. C.1 latency: 10 ROUND cycles, DONE for exactly one cycle
        send(C_PT, C_KEY, C_CT);
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("c1_last_r%0d", k), rnd_last_o, (k == 10));
            check($sformatf("c1_ovalid_r%0d", k), out_valid, 0);
`ifdef AES_SEQ_DBG_EN
            check($sformatf("c1_dbg_round_r%0d", k), dbg_round, k);
            check($sformatf("c1_dbg_fsm_r%0d", k), dbg_fsm, 1);
`endif
            step();
        end
        check("c1_ovalid_done", out_valid, 1);
        check("c1_last_done", rnd_last_o, 0);
        check("c1_busy_done", busy, 1);
`ifdef AES_SEQ_DBG_EN
        check("c1_dbg_fsm_done", dbg_fsm, 2);
`endif
        step();
        check("c1_ovalid_after", out_valid, 0);
        check("c1_in_ready_after", in_ready, 1);
`ifdef AES_SEQ_DBG_EN
        check("c1_dbg_fsm_idle", dbg_fsm, 0);
`endif
        drain();

        // Backpressure with a second request waiting
        out_ready = 1'b0;
        send(B_PT, B_KEY, B_CT);
        for (int c = 0; c < 30 && !out_valid; c++) step();
        check("bp_out_valid", out_valid, 1);
        plaintext = C_PT;
        key = C_KEY;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check("bp_in_ready", in_ready, 0);
            check("bp_ct_stable", ciphertext, B_CT);
            check("bp_out_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        send(C_PT, C_KEY, C_CT);
        drain();

        // Asynchronous reset while in round 5
        send(B_PT, B_KEY, B_CT);
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_rnd_state", rnd_state_o, 0);
        check("mid_rst_rnd_key", rnd_key_o, 0);
        check("mid_rst_rnd_last", rnd_last_o, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        #3;
        rst = 1'b0;
        step();
        for (int c = 0; c < 15; c++) begin
            check("post_rst_out_valid", out_valid, 0);
            step();
        end
        send(B_PT, B_KEY, B_CT);
        drain();

        // Input changes during ROUND must not disturb the captured block
        send(C_PT, C_KEY, C_CT);
        for (int c = 0; c < 10; c++) begin
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 encryption controller. It accepts a plaintext/key pair over a valid/ready handshake, performs the initial AddRoundKey, and then drives the shared single-round datapath (`AES_main`-style: SubBytes, ShiftRows, MixColumns, AddRoundKey) for rounds 1–10. Round keys are expanded on the fly, one per cycle. The ciphertext is returned over a second valid/ready handshake. It sits between the host-side request interface and the combinational round core.

## Interface
Parameters:
- `NR`, default 10: number of rounds. Only the AES-128 value is supported.

Ports:
- `clk`  in  1: single clock. All state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: block can accept a request.
- `plaintext`  in  128: input block. Byte 0 is in bits [127:120].
- `key`  in  128: cipher key, same byte order.
- `out_valid`  out  1: ciphertext valid.
- `out_ready`  in  1: consumer accepts the ciphertext.
- `ciphertext`  out  128: result.
- `rnd_state_o`  out  128: state presented to the round core.
- `rnd_key_o`  out  128: round key presented to the round core.
- `rnd_last_o`  out  1: final round, so the round core must skip MixColumns.
- `rnd_result_i`  in  128: combinational round-core output.
- `busy`  out  1: high when not in IDLE.

## Operation
- FSM states:
  - IDLE → ROUND on `in_valid && in_ready`.
  - ROUND → DONE when `round == NR`.
  - DONE → IDLE on `out_valid && out_ready`.
- Accept, at the IDLE handshake edge:
  - `state_r <= plaintext ^ key` (round-0 AddRoundKey).
  - `key_r <= key`.
  - `round <= 1`.
- Each ROUND cycle:
  - `rnd_key_o = key_step(key_r, RCON[round])`.
  - `rnd_state_o = state_r`.
  - `rnd_last_o = (round == NR)`.
  - At the edge: `state_r <= rnd_result_i`, `key_r <= rnd_key_o`, `round <= round + 1`.
- `key_step`:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
  - All XOR, no carries. `round` is 4 bits.
- RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- `ciphertext = state_r`. The value is held stable throughout DONE.
- Outside ROUND: `rnd_state_o`, `rnd_key_o` and `rnd_last_o` drive zero.
- `in_ready = (fsm == IDLE)`. Input changes while not in IDLE are ignored.
- `out_valid = (fsm == DONE)`. Once raised, it stays high until the `out_ready` handshake.

## Timing
- Reset values: `in_ready` = 1; `out_valid`, `busy`, `ciphertext`, `rnd_*_o` = 0; `round` = 0; FSM = IDLE.
- Latency: accept at edge E0, rounds at E1..E10. `out_valid` is high in the cycle after E10, i.e. 10 cycles after acceptance.
- The round core is purely combinational. Its path adds to the ROUND-state critical path, and no handshake is used toward it.
- Earliest next accept is the cycle after the DONE handshake. `in_ready` rises one cycle after `out_valid && out_ready`. Back-to-back throughput is 1 block per 12 cycles.
- `out_ready` held high in advance: the DONE state lasts exactly 1 cycle.
- `out_ready` low: DONE holds indefinitely with stable outputs.
- `rst` asserted mid-operation: immediate return to reset values. The in-flight block is discarded and no partial `out_valid` is produced.
- `in_valid` asserted during DONE: not accepted. The request must be held until `in_ready` is high.

## Configuration
- `AES_SEQ_DBG_EN`
  - Defined: adds output ports `dbg_round[3:0]` (current `round` register) and `dbg_fsm[1:0]` (IDLE = 0, ROUND = 1, DONE = 2). Both reset to 0.
  - Undefined: these ports and any logic behind them are absent. Functional behaviour is identical in both builds.

## Structure
- Shared package `aes_pkg` holds:
  - the `aes_fsm_t` enum;
  - the `RCON` constant array;
  - the `sbox` byte function;
  - the `NR`/`NK` constants.
- Sub-module `aes_key_step`: combinational one-step key expansion, with inputs `key_in[127:0]`, `rcon[7:0]` and output `key_out[127:0]`. It is reused later by the decrypt schedule.
- The bench instantiates the existing `AES_main`-style round core on the `rnd_*` ports.

## Test plan
- FIPS-197 App. B:
  - Stimulus: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: `rnd_state_o` in the first ROUND cycle = 193de3bea0f4e22b9ac68d2ae9f84808; `rnd_key_o` = a0fafe1788542cb123a339392a6c7605; `ciphertext` = 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1:
  - Stimulus: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, `out_ready` tied high.
  - Required: ct = 69c4e0d86a7b0430d8cdb78070b4c55a; `out_valid` high exactly 1 cycle, exactly 10 cycles after accept; `rnd_last_o` high only in the 10th ROUND cycle.
- Backpressure:
  - Stimulus: `out_ready` = 0 for 20 cycles after `out_valid`, and a second request (App. C.1 vectors) presented meanwhile.
  - Required: `in_ready` stays 0; `ciphertext` is stable; the second block is accepted only after the handshake and yields 69c4e0d8….
- Reset mid-flight:
  - Stimulus: assert `rst` asynchronously (between edges) in ROUND at round 5.
  - Required: `busy`, `out_valid` and `rnd_*_o` drop to 0 at once without a clock; no `out_valid` is produced afterwards; a fresh App. B request then yields 3925841d….
- Ignored input:
  - Stimulus: toggle `plaintext`/`key` every cycle while in ROUND.
  - Required: the result still equals the vector captured at accept.
- With `AES_SEQ_DBG_EN` defined:
  - Required: `dbg_round` steps 1..10 through ROUND; `dbg_fsm` sequence is 0 → 1 → 2 → 0.
